// File: rtl/mem_arbiter_if.sv
// Bundles the icache, dcache and external memory word ports seen by mem_arbiter.
interface mem_arbiter_if;
  // icache side
  logic [31:0] i_imem_addr;
  logic        i_imem_ren;
  logic        i_imem_wen;
  logic [31:0] i_imem_wdata;
  logic        o_imem_ready;
  logic [31:0] o_imem_rdata;
  logic        o_imem_valid;
  // dcache side
  logic [31:0] i_dmem_addr;
  logic        i_dmem_ren;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_wdata;
  logic        o_dmem_ready;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_valid;
  // external memory side
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_valid;

  // Arbiter view
  modport slave (
    input  i_imem_addr, i_imem_ren, i_imem_wen, i_imem_wdata,
    output o_imem_ready, o_imem_rdata, o_imem_valid,
    input  i_dmem_addr, i_dmem_ren, i_dmem_wen, i_dmem_wdata,
    output o_dmem_ready, o_dmem_rdata, o_dmem_valid,
    input  i_mem_ready, i_mem_rdata, i_mem_valid,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata
  );

  // Environment view (caches + memory)
  modport master (
    output i_imem_addr, i_imem_ren, i_imem_wen, i_imem_wdata,
    input  o_imem_ready, o_imem_rdata, o_imem_valid,
    output i_dmem_addr, i_dmem_ren, i_dmem_wen, i_dmem_wdata,
    input  o_dmem_ready, o_dmem_rdata, o_dmem_valid,
    output i_mem_ready, i_mem_rdata, i_mem_valid,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin merge of icache/dcache word ports onto one memory port, with an
// in-order owner-tag FIFO steering each read response back to its issuer.
module mem_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus,
  output logic          o_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_e;

  logic [DEPTH-1:0] fifo_q, fifo_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  owner_e           rr_last_q, rr_last_d;
  logic             err_q, err_d;

  grant_e grant;
  logic   slot_free, i_elig, d_elig;
  logic   accept, push, pop, spurious;
  owner_e head_owner;

  // Eligibility and round-robin grant; a same-cycle response frees a slot
  always_comb begin
    slot_free = (count_q < FULL) | bus.i_mem_valid;
    i_elig    = bus.i_imem_wen | (bus.i_imem_ren & slot_free);
    d_elig    = bus.i_dmem_wen | (bus.i_dmem_ren & slot_free);
    grant     = GNT_NONE;
    if (i_elig && d_elig) begin
      grant = (rr_last_q == OWN_D) ? GNT_I : GNT_D;
    end else if (i_elig) begin
      grant = GNT_I;
    end else if (d_elig) begin
      grant = GNT_D;
    end
  end

  // Forward the granted port to memory and return ready to it only
  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_wdata = '0;
    case (grant)
      GNT_I: begin
        bus.o_mem_addr  = bus.i_imem_addr;
        bus.o_mem_ren   = bus.i_imem_ren;
        bus.o_mem_wen   = bus.i_imem_wen;
        bus.o_mem_wdata = bus.i_imem_wdata;
      end
      GNT_D: begin
        bus.o_mem_addr  = bus.i_dmem_addr;
        bus.o_mem_ren   = bus.i_dmem_ren;
        bus.o_mem_wen   = bus.i_dmem_wen;
        bus.o_mem_wdata = bus.i_dmem_wdata;
      end
      default: ;
    endcase
    bus.o_imem_ready = bus.i_mem_ready & (grant == GNT_I);
    bus.o_dmem_ready = bus.i_mem_ready & (grant == GNT_D);
  end

  // Owner FIFO next state; pop reads the old head while push writes the tail
  always_comb begin
    accept     = bus.i_mem_ready & (bus.o_mem_ren | bus.o_mem_wen);
    push       = accept & bus.o_mem_ren;
    pop        = bus.i_mem_valid & (count_q != '0);
    spurious   = bus.i_mem_valid & (count_q == '0);
    head_owner = owner_e'(fifo_q[head_q]);

    fifo_d = fifo_q;
    if (push) begin
      fifo_d[tail_q] = (grant == GNT_D);
    end
    tail_d = push ? tail_q + PTR_ONE : tail_q;
    head_d = pop  ? head_q + PTR_ONE : head_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    rr_last_d = rr_last_q;
    if (accept) begin
      rr_last_d = (grant == GNT_D) ? OWN_D : OWN_I;
    end
    err_d = err_q | spurious;
  end

  // Route the memory response to the owner at the FIFO head, zero otherwise
  always_comb begin
    bus.o_imem_valid = pop & (head_owner == OWN_I);
    bus.o_dmem_valid = pop & (head_owner == OWN_D);
    bus.o_imem_rdata = bus.o_imem_valid ? bus.i_mem_rdata : '0;
    bus.o_dmem_rdata = bus.o_dmem_valid ? bus.i_mem_rdata : '0;
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rr_last_q <= OWN_D;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rr_last_q <= rr_last_d;
      err_q     <= err_d;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a queue-based model.
module tb_mem_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  logic err_o;

  mem_arbiter #(.DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus),
    .o_err (err_o)
  );

  // Stimulus variables
  logic        iren = 0, iwen = 0, dren = 0, dwen = 0, mready = 0, mvalid = 0;
  logic [31:0] iaddr = 0, iwdata = 0, daddr = 0, dwdata = 0, mrdata = 0;

  assign bus.i_imem_addr  = iaddr;
  assign bus.i_imem_ren   = iren;
  assign bus.i_imem_wen   = iwen;
  assign bus.i_imem_wdata = iwdata;
  assign bus.i_dmem_addr  = daddr;
  assign bus.i_dmem_ren   = dren;
  assign bus.i_dmem_wen   = dwen;
  assign bus.i_dmem_wdata = dwdata;
  assign bus.i_mem_ready  = mready;
  assign bus.i_mem_valid  = mvalid;
  assign bus.i_mem_rdata  = mrdata;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model: outstanding owners (0=I,1=D), last winner, sticky error
  bit own_q[$];
  bit rr_last = 1'b1;
  bit err = 1'b0;
  // Memory model: pending read addresses with accept cycle, written words
  logic [31:0] pend[$];
  int          pend_t[$];
  logic [31:0] mem [logic [31:0]];

  // Expected values for the current cycle
  int          e_gnt;
  logic        e_ren, e_wen, e_iready, e_dready, e_ivalid, e_dvalid, e_err;
  logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
  bit          e_accept, e_pop, e_spur;

  function automatic logic [31:0] memword(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit resp_due(int lat);
    return (pend.size() > 0) && ((cyc - pend_t[0]) >= lat);
  endfunction

  function automatic void model_eval();
    int cnt = own_q.size();
    bit free, ie, de;
    free = (cnt < DEPTH) || mvalid;
    ie = iwen || (iren && free);
    de = dwen || (dren && free);
    if (ie && de)  e_gnt = rr_last ? 1 : 2;
    else if (ie)   e_gnt = 1;
    else if (de)   e_gnt = 2;
    else           e_gnt = 0;
    {e_ren, e_wen, e_addr, e_wdata} = '0;
    if (e_gnt == 1) {e_ren, e_wen, e_addr, e_wdata} = {iren, iwen, iaddr, iwdata};
    if (e_gnt == 2) {e_ren, e_wen, e_addr, e_wdata} = {dren, dwen, daddr, dwdata};
    e_iready = mready && (e_gnt == 1);
    e_dready = mready && (e_gnt == 2);
    e_accept = mready && (e_ren || e_wen);
    e_pop    = mvalid && (cnt > 0);
    e_spur   = mvalid && (cnt == 0);
    e_ivalid = 1'b0;
    e_dvalid = 1'b0;
    if (e_pop) begin
      e_ivalid = (own_q[0] == 1'b0);
      e_dvalid = (own_q[0] == 1'b1);
    end
    e_irdata = e_ivalid ? mrdata : 32'h0;
    e_drdata = e_dvalid ? mrdata : 32'h0;
    e_err    = err;
  endfunction

  // Apply inputs (memory supplies head word on a response) and evaluate model
  task automatic drive();
    if (mvalid && pend.size() > 0) mrdata = memword(pend[0]);
    else                           mrdata = $urandom();
    #1;
    model_eval();
  endtask

  // Commit the model for this cycle and advance to the next negedge
  task automatic tick();
    if (rst) begin
      own_q.delete(); pend.delete(); pend_t.delete();
      rr_last = 1'b1; err = 1'b0;
    end else begin
      if (e_pop) begin
        void'(own_q.pop_front());
        void'(pend.pop_front());
        void'(pend_t.pop_front());
      end
      if (e_accept && e_ren) begin
        own_q.push_back(e_gnt == 2);
        pend.push_back(e_addr);
        pend_t.push_back(cyc);
      end
      if (e_accept && e_wen) mem[e_addr] = e_wdata;
      if (e_accept) rr_last = (e_gnt == 2);
      if (e_spur) err = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    {iren, iwen, dren, dwen, mvalid} = '0;
    mready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    drive(); tick();
    drive(); tick();
    rst = 1'b0;
    drive();
    n_total++;
    if ({bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata} !== 66'h0) begin
      $display("FAIL reset_fwd got ren=%b wen=%b addr=%h wdata=%h exp all 0",
               bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata);
    end else n_pass++;
    n_total++;
    if ({bus.o_imem_ready, bus.o_dmem_ready, bus.o_imem_valid, bus.o_dmem_valid,
         bus.o_imem_rdata, bus.o_dmem_rdata, err_o} !== 69'h0) begin
      $display("FAIL reset_outs got irdy=%b drdy=%b ival=%b dval=%b ird=%h drd=%h err=%b exp all 0",
               bus.o_imem_ready, bus.o_dmem_ready, bus.o_imem_valid, bus.o_dmem_valid,
               bus.o_imem_rdata, bus.o_dmem_rdata, err_o);
    end else n_pass++;
    tick();
  endtask

  task automatic test_single_read();
    idle();
    dren = 1'b1; daddr = 32'h40;
    drive();
    n_total++;
    if ({bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_dmem_ready, bus.o_imem_ready}
        !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b0}) begin
      $display("FAIL single_issue got ren=%b wen=%b addr=%h drdy=%b irdy=%b exp 1 0 00000040 1 0",
               bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_dmem_ready, bus.o_imem_ready);
    end else n_pass++;
    tick();
    dren = 1'b0;
    drive();
    n_total++;
    if ({bus.o_dmem_valid, bus.o_imem_valid} !== 2'b00) begin
      $display("FAIL single_wait got dval=%b ival=%b exp 0 0", bus.o_dmem_valid, bus.o_imem_valid);
    end else n_pass++;
    tick();
    mvalid = resp_due(2);
    drive();
    n_total++;
    if ({bus.o_dmem_valid, bus.o_imem_valid, bus.o_dmem_rdata, bus.o_imem_rdata}
        !== {1'b1, 1'b0, memword(32'h40), 32'h0}) begin
      $display("FAIL single_resp got dval=%b ival=%b drd=%h ird=%h exp 1 0 %h 0",
               bus.o_dmem_valid, bus.o_imem_valid, bus.o_dmem_rdata, bus.o_imem_rdata,
               memword(32'h40));
    end else n_pass++;
    tick();
    mvalid = 1'b0;
  endtask

  task automatic test_stream();
    int ia = 0, da = 0;
    logic [31:0] acc_log[$];
    bit resp_log[$];
    bit rdy_i, rdy_d;
    idle();
    for (int c = 0; c < 60 && (acc_log.size() < 8 || resp_log.size() < 8); c++) begin
      iren = (ia < 4); iaddr = 32'h100 + 32'(4 * ia);
      dren = (da < 4); daddr = 32'h200 + 32'(4 * da);
      mvalid = resp_due(2);
      drive();
      n_total++;
      if ({bus.o_mem_ren, bus.o_mem_addr, bus.o_imem_ready, bus.o_dmem_ready}
          !== {e_ren, e_addr, e_iready, e_dready}) begin
        $display("FAIL stream_fwd c=%0d got ren=%b addr=%h irdy=%b drdy=%b exp %b %h %b %b",
                 c, bus.o_mem_ren, bus.o_mem_addr, bus.o_imem_ready, bus.o_dmem_ready,
                 e_ren, e_addr, e_iready, e_dready);
      end else n_pass++;
      n_total++;
      if ({bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata}
          !== {e_ivalid, e_dvalid, e_irdata, e_drdata}) begin
        $display("FAIL stream_rsp c=%0d got ival=%b dval=%b ird=%h drd=%h exp %b %b %h %h",
                 c, bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata,
                 e_ivalid, e_dvalid, e_irdata, e_drdata);
      end else n_pass++;
      if (bus.o_mem_ren) acc_log.push_back(bus.o_mem_addr);
      if (bus.o_imem_valid) resp_log.push_back(1'b0);
      if (bus.o_dmem_valid) resp_log.push_back(1'b1);
      rdy_i = bus.o_imem_ready; rdy_d = bus.o_dmem_ready;
      tick();
      if (rdy_i) ia++;
      if (rdy_d) da++;
    end
    idle();
    n_total++;
    if (acc_log.size() != 8 || resp_log.size() != 8) begin
      $display("FAIL stream_count got acc=%0d rsp=%0d exp 8 8", acc_log.size(), resp_log.size());
    end else begin
      n_pass++;
      for (int k = 0; k < 8; k++) begin
        logic [31:0] ea;
        ea = ((k % 2) == 0 ? 32'h100 : 32'h200) + 32'(4 * (k / 2));
        n_total++;
        if (acc_log[k] !== ea || resp_log[k] !== bit'(k % 2)) begin
          $display("FAIL stream_order k=%0d got addr=%h owner=%0d exp addr=%h owner=%0d",
                   k, acc_log[k], resp_log[k], ea, k % 2);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int ia = 0, da = 0;
    bit rdy_i, rdy_d;
    idle();
    for (int c = 0; c < 7; c++) begin
      iren = 1'b1; iaddr = 32'h400 + 32'(4 * ia);
      dren = 1'b1; daddr = 32'h500 + 32'(4 * da);
      mvalid = (c == 5) && (pend.size() > 0);
      drive();
      if (c >= 4 && c != 5) begin
        n_total++;
        if ({bus.o_imem_ready, bus.o_dmem_ready, bus.o_mem_ren} !== 3'b000) begin
          $display("FAIL stall_hold c=%0d got irdy=%b drdy=%b ren=%b exp 0 0 0",
                   c, bus.o_imem_ready, bus.o_dmem_ready, bus.o_mem_ren);
        end else n_pass++;
      end
      if (c == 5) begin
        n_total++;
        if ({bus.o_mem_ren, bus.o_imem_ready | bus.o_dmem_ready, bus.o_imem_ready, bus.o_imem_valid}
            !== {1'b1, 1'b1, e_iready, e_ivalid}) begin
          $display("FAIL stall_pop_push got ren=%b irdy=%b drdy=%b ival=%b exp ren=1 irdy=%b ival=%b",
                   bus.o_mem_ren, bus.o_imem_ready, bus.o_dmem_ready, bus.o_imem_valid,
                   e_iready, e_ivalid);
        end else n_pass++;
      end
      rdy_i = bus.o_imem_ready; rdy_d = bus.o_dmem_ready;
      tick();
      if (rdy_i) ia++;
      if (rdy_d) da++;
    end
    idle();
    for (int c = 0; c < 4; c++) begin
      mvalid = 1'b1;
      drive();
      n_total++;
      if ({bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata}
          !== {e_ivalid, e_dvalid, e_irdata, e_drdata} || !(e_ivalid || e_dvalid)) begin
        $display("FAIL stall_drain c=%0d got ival=%b dval=%b ird=%h drd=%h exp %b %b %h %h",
                 c, bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata,
                 e_ivalid, e_dvalid, e_irdata, e_drdata);
      end else n_pass++;
      tick();
    end
    mvalid = 1'b0;
  endtask

  task automatic test_write();
    idle();
    iren = 1'b1; iaddr = 32'h300;
    drive();
    n_total++;
    if ({bus.o_imem_ready, bus.o_mem_ren} !== 2'b11) begin
      $display("FAIL write_iread got irdy=%b ren=%b exp 1 1", bus.o_imem_ready, bus.o_mem_ren);
    end else n_pass++;
    tick();
    iren = 1'b0;
    dwen = 1'b1; daddr = 32'h80; dwdata = 32'hDEAD_BEEF;
    drive();
    n_total++;
    if ({bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_dmem_ready}
        !== {1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 1'b1}) begin
      $display("FAIL write_fwd got ren=%b wen=%b addr=%h wdata=%h drdy=%b exp 0 1 00000080 deadbeef 1",
               bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_dmem_ready);
    end else n_pass++;
    tick();
    dwen = 1'b0;
    mvalid = 1'b1;
    drive();
    n_total++;
    if ({bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata}
        !== {1'b1, 1'b0, memword(32'h300)}) begin
      $display("FAIL write_route got ival=%b dval=%b ird=%h exp 1 0 %h",
               bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, memword(32'h300));
    end else n_pass++;
    tick();
    mvalid = 1'b0;
    dren = 1'b1; daddr = 32'h80;
    drive(); tick();
    dren = 1'b0;
    mvalid = 1'b1;
    drive();
    n_total++;
    if ({bus.o_dmem_valid, bus.o_dmem_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      $display("FAIL write_readback got dval=%b drd=%h exp 1 deadbeef",
               bus.o_dmem_valid, bus.o_dmem_rdata);
    end else n_pass++;
    tick();
    mvalid = 1'b0;
  endtask

  task automatic test_spurious();
    idle();
    mvalid = 1'b1;
    drive();
    n_total++;
    if ({bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata, err_o} !== 67'h0) begin
      $display("FAIL spur_drop got ival=%b dval=%b ird=%h drd=%h err=%b exp all 0",
               bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata, err_o);
    end else n_pass++;
    tick();
    mvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive();
      n_total++;
      if (err_o !== 1'b1) $display("FAIL spur_sticky c=%0d got err=%b exp 1", c, err_o);
      else n_pass++;
      tick();
    end
    rst = 1'b1; drive(); tick(); rst = 1'b0;
    drive();
    n_total++;
    if (err_o !== 1'b0) $display("FAIL spur_clear got err=%b exp 0", err_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bit rdy_i, rdy_d;
    idle();
    iren = 1'b1; iaddr = 32'h600;
    dren = 1'b1; daddr = 32'h700;
    for (int c = 0; c < 3; c++) begin
      drive();
      rdy_i = bus.o_imem_ready; rdy_d = bus.o_dmem_ready;
      tick();
      if (rdy_i) iaddr += 32'h4;
      if (rdy_d) daddr += 32'h4;
    end
    idle();
    rst = 1'b1; drive(); tick(); rst = 1'b0;
    mvalid = 1'b1;
    drive();
    n_total++;
    if ({bus.o_imem_valid, bus.o_dmem_valid} !== 2'b00) begin
      $display("FAIL rstmid_lost got ival=%b dval=%b exp 0 0", bus.o_imem_valid, bus.o_dmem_valid);
    end else n_pass++;
    tick();
    mvalid = 1'b0;
    iren = 1'b1; iaddr = 32'h800;
    dren = 1'b1; daddr = 32'h900;
    drive();
    n_total++;
    if ({err_o, bus.o_imem_ready, bus.o_dmem_ready, bus.o_mem_addr}
        !== {1'b1, 1'b1, 1'b0, 32'h800}) begin
      $display("FAIL rstmid_tie got err=%b irdy=%b drdy=%b addr=%h exp 1 1 0 00000800",
               err_o, bus.o_imem_ready, bus.o_dmem_ready, bus.o_mem_addr);
    end else n_pass++;
    tick();
    iren = 1'b0;
    drive();
    n_total++;
    if ({bus.o_dmem_ready, bus.o_mem_addr} !== {1'b1, 32'h900}) begin
      $display("FAIL rstmid_next got drdy=%b addr=%h exp 1 00000900", bus.o_dmem_ready, bus.o_mem_addr);
    end else n_pass++;
    tick();
    idle();
    rst = 1'b1; drive(); tick(); rst = 1'b0;
  endtask

  task automatic test_random();
    bit i_act = 0, i_wr = 0, d_act = 0, d_wr = 0;
    bit rdy_i, rdy_d;
    for (int c = 0; c < 400; c++) begin
      if (!i_act && ($urandom_range(0, 2) == 0)) begin
        i_act = 1'b1; i_wr = ($urandom_range(0, 7) == 0);
        iaddr = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4; iwdata = $urandom();
      end
      if (!d_act && ($urandom_range(0, 2) == 0)) begin
        d_act = 1'b1; d_wr = ($urandom_range(0, 2) == 0);
        daddr = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4; dwdata = $urandom();
      end
      iren = i_act && !i_wr; iwen = i_act && i_wr;
      dren = d_act && !d_wr; dwen = d_act && d_wr;
      mready = ($urandom_range(0, 3) != 0);
      mvalid = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      drive();
      n_total++;
      if ({bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_imem_ready, bus.o_dmem_ready}
          !== {e_ren, e_wen, e_addr, e_wdata, e_iready, e_dready}) begin
        $display("FAIL rnd_fwd c=%0d got ren=%b wen=%b addr=%h wd=%h irdy=%b drdy=%b exp %b %b %h %h %b %b",
                 c, bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata,
                 bus.o_imem_ready, bus.o_dmem_ready, e_ren, e_wen, e_addr, e_wdata, e_iready, e_dready);
      end else n_pass++;
      n_total++;
      if ({bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata, err_o}
          !== {e_ivalid, e_dvalid, e_irdata, e_drdata, e_err}) begin
        $display("FAIL rnd_rsp c=%0d got ival=%b dval=%b ird=%h drd=%h err=%b exp %b %b %h %h %b",
                 c, bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata, err_o,
                 e_ivalid, e_dvalid, e_irdata, e_drdata, e_err);
      end else n_pass++;
      rdy_i = bus.o_imem_ready; rdy_d = bus.o_dmem_ready;
      tick();
      if (rdy_i) i_act = 1'b0;
      if (rdy_d) d_act = 1'b0;
    end
    idle();
    for (int c = 0; c < 20 && pend.size() > 0; c++) begin
      mvalid = 1'b1;
      drive();
      n_total++;
      if ({bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata}
          !== {e_ivalid, e_dvalid, e_irdata, e_drdata}) begin
        $display("FAIL rnd_drain c=%0d got ival=%b dval=%b ird=%h drd=%h exp %b %b %h %h",
                 c, bus.o_imem_valid, bus.o_dmem_valid, bus.o_imem_rdata, bus.o_dmem_rdata,
                 e_ivalid, e_dvalid, e_irdata, e_drdata);
      end else n_pass++;
      tick();
    end
    mvalid = 1'b0;
    n_total++;
    if (pend.size() != 0) $display("FAIL rnd_drain_timeout got pending=%0d exp 0", pend.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_stream();
    test_stall();
    test_write();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got time limit reached exp finish");
    $fatal(1, "watchdog");
  end

endmodule
